// File: rtl/riscv_enc_pkg.sv
// Shared RISC-V encoding constants, op enum and request struct for the instruction encoder.
package riscv_enc_pkg;

   typedef enum logic [2:0] {
      I_ADD  = 3'd0,
      I_SUB  = 3'd1,
      I_AND  = 3'd2,
      I_OR   = 3'd3,
      I_ADDI = 3'd4,
      I_LD   = 3'd5,
      I_SD   = 3'd6,
      I_BEQ  = 3'd7
   } op_e;

   typedef struct packed {
      op_e         op;
      logic [4:0]  rd;
      logic [4:0]  rs1;
      logic [4:0]  rs2;
      logic [63:0] imm;
   } enc_req_t;

   localparam logic [6:0] OP_R      = 7'b0110011;
   localparam logic [6:0] OP_IMM    = 7'b0010011;
   localparam logic [6:0] OP_LOAD   = 7'b0000011;
   localparam logic [6:0] OP_STORE  = 7'b0100011;
   localparam logic [6:0] OP_BRANCH = 7'b1100011;

   localparam logic [2:0] F3_ADD = 3'b000;
   localparam logic [2:0] F3_AND = 3'b111;
   localparam logic [2:0] F3_OR  = 3'b110;
   localparam logic [2:0] F3_D   = 3'b011;
   localparam logic [2:0] F3_BEQ = 3'b000;

   localparam logic [6:0] F7_BASE = 7'b0000000;
   localparam logic [6:0] F7_SUB  = 7'b0100000;

   localparam logic [31:0] NOP = 32'h0000_0013;

   function automatic logic [7:0] sat_inc8(input logic [7:0] v);
      return (v == 8'hFF) ? 8'hFF : v + 8'd1;
   endfunction

endpackage

// File: rtl/instr_encoder_if.sv
// Request/response stream between the loader and the instruction encoder.
interface instr_encoder_if import riscv_enc_pkg::*; #(parameter int ADDR_W = 8);
   logic              in_valid;
   logic              in_ready;
   op_e               in_op;
   logic [4:0]        in_rd;
   logic [4:0]        in_rs1;
   logic [4:0]        in_rs2;
   logic [63:0]       in_imm;
   logic              addr_clr;
   logic              out_valid;
   logic              out_ready;
   logic [31:0]       out_instr;
   logic [ADDR_W-1:0] out_addr;
   logic              out_err;
   logic [7:0]        err_cnt;

   modport master (
      output in_valid, in_op, in_rd, in_rs1, in_rs2, in_imm, addr_clr, out_ready,
      input  in_ready, out_valid, out_instr, out_addr, out_err, err_cnt
   );

   modport slave (
      input  in_valid, in_op, in_rd, in_rs1, in_rs2, in_imm, addr_clr, out_ready,
      output in_ready, out_valid, out_instr, out_addr, out_err, err_cnt
   );
endinterface

// File: rtl/instr_pack.sv
// Combinational field packing of one symbolic instruction plus the 12-bit immediate range check.
module instr_pack import riscv_enc_pkg::*; (
   input  enc_req_t    req,
   output logic [31:0] instr,
   output logic        err
);

   logic [11:0] v;
   logic        in_range;
   logic        r_type;

   assign v        = req.imm[11:0];
   assign in_range = (req.imm == {{52{v[11]}}, v});
   assign r_type   = (req.op == I_ADD) || (req.op == I_SUB) ||
                     (req.op == I_AND) || (req.op == I_OR);

   always_comb begin
      instr = NOP;
      err   = 1'b0;
      unique case (req.op)
         I_ADD:  instr = {F7_BASE, req.rs2, req.rs1, F3_ADD, req.rd, OP_R};
         I_SUB:  instr = {F7_SUB,  req.rs2, req.rs1, F3_ADD, req.rd, OP_R};
         I_AND:  instr = {F7_BASE, req.rs2, req.rs1, F3_AND, req.rd, OP_R};
         I_OR:   instr = {F7_BASE, req.rs2, req.rs1, F3_OR,  req.rd, OP_R};
         I_ADDI: instr = {v, req.rs1, F3_ADD, req.rd, OP_IMM};
         I_LD:   instr = {v, req.rs1, F3_D,   req.rd, OP_LOAD};
         I_SD:   instr = {v[11:5], req.rs2, req.rs1, F3_D, v[4:0], OP_STORE};
         // imm is already the halfword offset, so v[0] lands in inst[8]
         I_BEQ:  instr = {v[11], v[9:4], req.rs2, req.rs1, F3_BEQ, v[3:0], v[10], OP_BRANCH};
         default: instr = NOP;
      endcase
      if (!r_type && !in_range) begin
         instr = NOP;
         err   = 1'b1;
      end
   end

endmodule

// File: rtl/instr_encoder.sv
// Encoder top: output register with valid/ready, write-address counter and saturating error count.
module instr_encoder import riscv_enc_pkg::*; #(
   parameter int ADDR_W    = 8,
   parameter int BASE_ADDR = 0
) (
   input  logic           clk,
   input  logic           rst_n,
   instr_encoder_if.slave bus
);

   localparam logic [ADDR_W-1:0] BASE_A = ADDR_W'(BASE_ADDR);
   localparam logic [ADDR_W-1:0] STEP   = ADDR_W'(4);

   enc_req_t          req;
   logic [31:0]       p_instr;
   logic              p_err;
   logic              vld, err_q, rdy, acc;
   logic [31:0]       instr_q;
   logic [ADDR_W-1:0] addr_q, cnt, cnt_base;
   logic [7:0]        ecnt, ecnt_base;

   assign req = '{op: bus.in_op, rd: bus.in_rd, rs1: bus.in_rs1, rs2: bus.in_rs2, imm: bus.in_imm};

   instr_pack u_pack (.req(req), .instr(p_instr), .err(p_err));

   assign rdy = !vld || bus.out_ready;
   assign acc = bus.in_valid && rdy;

   // addr_clr takes effect before the accepted word picks its address
   assign cnt_base  = bus.addr_clr ? BASE_A : cnt;
   assign ecnt_base = bus.addr_clr ? 8'd0   : ecnt;

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         vld     <= 1'b0;
         instr_q <= '0;
         addr_q  <= BASE_A;
         err_q   <= 1'b0;
         cnt     <= BASE_A;
         ecnt    <= '0;
      end else begin
         if (rdy) vld <= acc;
         if (acc) begin
            instr_q <= p_instr;
            err_q   <= p_err;
            addr_q  <= cnt_base;
            cnt     <= p_err ? cnt_base : cnt_base + STEP;
            ecnt    <= p_err ? sat_inc8(ecnt_base) : ecnt_base;
         end else if (bus.addr_clr) begin
            cnt  <= BASE_A;
            ecnt <= '0;
         end
      end
   end

   assign bus.in_ready  = rdy;
   assign bus.out_valid = vld;
   assign bus.out_instr = instr_q;
   assign bus.out_addr  = addr_q;
   assign bus.out_err   = err_q;
   assign bus.err_cnt   = ecnt;

endmodule

// File: tb/tb_instr_encoder.sv
// Directed bench for instr_encoder: encodings, range errors, backpressure, wrap/clear, async reset, round trip.
module tb_instr_encoder;
   import riscv_enc_pkg::*;

   logic clk = 1'b0;
   logic rst_n;
   int   errors = 0;
   int   checks = 0;

   always #5 clk = ~clk;

   instr_encoder_if #(.ADDR_W(8)) a ();
   instr_encoder_if #(.ADDR_W(4)) b ();

   instr_encoder #(.ADDR_W(8), .BASE_ADDR(0)) dut_a (.clk(clk), .rst_n(rst_n), .bus(a));
   instr_encoder #(.ADDR_W(4), .BASE_ADDR(0)) dut_b (.clk(clk), .rst_n(rst_n), .bus(b));

   task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
      checks++;
      assert (obs === exp) else begin
         errors++;
         $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
      end
   endtask

   task automatic set_in(input op_e op, input int rd, input int rs1, input int rs2, input logic [63:0] imm);
      a.in_op  = op;
      a.in_rd  = 5'(rd);
      a.in_rs1 = 5'(rs1);
      a.in_rs2 = 5'(rs2);
      a.in_imm = imm;
   endtask

   // present one word for one clock, then sample just after the edge
   task automatic send(input op_e op, input int rd, input int rs1, input int rs2, input logic [63:0] imm);
      @(negedge clk);
      set_in(op, rd, rs1, rs2, imm);
      a.in_valid = 1'b1;
      @(posedge clk);
      #1;
      a.in_valid = 1'b0;
   endtask

   task automatic expect_word(input string tag, input logic [31:0] instr, input logic [7:0] addr, input logic err);
      chk({tag, ".valid"}, 64'(a.out_valid), 64'd1);
      chk({tag, ".instr"}, 64'(a.out_instr), 64'(instr));
      chk({tag, ".addr"},  64'(a.out_addr),  64'(addr));
      chk({tag, ".err"},   64'(a.out_err),   64'(err));
   endtask

   // independent model of the core's immediate generator
   function automatic logic [63:0] immgen(input logic [31:0] i);
      case (i[6:0])
         7'b0010011, 7'b0000011: immgen = {{52{i[31]}}, i[31:20]};
         7'b0100011:             immgen = {{52{i[31]}}, i[31:25], i[11:7]};
         7'b1100011:             immgen = {{51{i[31]}}, i[31], i[7], i[30:25], i[11:8], 1'b0};
         default:                immgen = '0;
      endcase
   endfunction

   initial begin
      rst_n = 1'b0;
      a.in_valid = 0; a.addr_clr = 0; a.out_ready = 1;
      set_in(I_ADD, 0, 0, 0, 64'd0);
      b.in_valid = 0; b.addr_clr = 0; b.out_ready = 1;
      b.in_op = I_ADDI; b.in_rd = 0; b.in_rs1 = 0; b.in_rs2 = 0; b.in_imm = 0;
      #12;
      chk("rst.valid",  64'(a.out_valid), 64'd0);
      chk("rst.instr",  64'(a.out_instr), 64'd0);
      chk("rst.addr",   64'(a.out_addr),  64'd0);
      chk("rst.err",    64'(a.out_err),   64'd0);
      chk("rst.errcnt", 64'(a.err_cnt),   64'd0);
      chk("rst.ready",  64'(a.in_ready),  64'd1);
      @(negedge clk);
      rst_n = 1'b1;

      // directed encodings; unused fields carry junk that must not leak
      send(I_ADDI, 5, 0, 31, -64'sd1);       expect_word("addi", 32'hFFF00293, 8'd0, 1'b0);
      send(I_LD, 6, 2, 0, 64'd16);           expect_word("ld",   32'h01013303, 8'd4, 1'b0);
      send(I_SD, 31, 2, 6, 64'd8);           expect_word("sd",   32'h00613423, 8'd8, 1'b0);
      send(I_SUB, 1, 2, 3, 64'hDEAD_BEEF);   expect_word("sub",  32'h403100B3, 8'd12, 1'b0);
      send(I_BEQ, 0, 1, 2, -64'sd2);         expect_word("beq",  32'hFE208EE3, 8'd16, 1'b0);

      // range boundaries
      send(I_ADDI, 5, 0, 0, 64'd2048);       expect_word("err2048", 32'h00000013, 8'd20, 1'b1);
      chk("err2048.cnt", 64'(a.err_cnt), 64'd1);
      send(I_ADDI, 1, 1, 0, 64'd2047);       expect_word("imm2047", 32'h7FF08093, 8'd20, 1'b0);
      send(I_ADDI, 0, 0, 0, -64'sd2048);     expect_word("immm2048", 32'h80000013, 8'd24, 1'b0);
      send(I_SD, 0, 1, 1, -64'sd2049);       expect_word("errm2049", 32'h00000013, 8'd28, 1'b1);
      chk("errm2049.cnt", 64'(a.err_cnt), 64'd2);
      send(I_ADD, 3, 4, 5, 64'h1_2345_6789); expect_word("add", 32'h005201B3, 8'd28, 1'b0);
      send(I_AND, 7, 8, 9, 64'd0);           expect_word("and", 32'h009473B3, 8'd32, 1'b0);
      send(I_OR, 10, 11, 12, 64'd0);         expect_word("or",  32'h00C5E533, 8'd36, 1'b0);

      // backpressure: OR word held while a new word waits
      @(negedge clk);
      a.out_ready = 1'b0;
      set_in(I_ADDI, 1, 0, 0, 64'd1);
      a.in_valid = 1'b1;
      for (int i = 0; i < 3; i++) begin
         @(posedge clk);
         #1;
         chk("bp.ready", 64'(a.in_ready), 64'd0);
         expect_word("bp.hold", 32'h00C5E533, 8'd36, 1'b0);
      end
      @(negedge clk);
      a.out_ready = 1'b1;
      @(posedge clk);
      #1;
      a.in_valid = 1'b0;
      expect_word("bp.w1", 32'h00100093, 8'd40, 1'b0);
      send(I_ADDI, 2, 0, 0, 64'd2);          expect_word("bp.w2", 32'h00200113, 8'd44, 1'b0);
      send(I_ADDI, 3, 0, 0, 64'd3);          expect_word("bp.w3", 32'h00300193, 8'd48, 1'b0);
      @(posedge clk);
      #1;
      chk("bp.drain", 64'(a.out_valid), 64'd0);

      // wrap on a 4-bit address counter
      for (int i = 0; i < 5; i++) begin
         @(negedge clk);
         b.in_rd = 5'(i); b.in_imm = 64'(i);
         b.in_valid = 1'b1;
         @(posedge clk);
         #1;
         b.in_valid = 1'b0;
         chk($sformatf("wrap.addr%0d", i), 64'(b.out_addr), 64'((i * 4) % 16));
      end

      // addr_clr with a simultaneous accept
      @(negedge clk);
      a.addr_clr = 1'b1;
      set_in(I_ADDI, 4, 0, 0, 64'd4);
      a.in_valid = 1'b1;
      @(posedge clk);
      #1;
      a.in_valid = 1'b0;
      a.addr_clr = 1'b0;
      expect_word("clr.w", 32'h00400213, 8'd0, 1'b0);
      chk("clr.cnt", 64'(a.err_cnt), 64'd0);
      send(I_ADDI, 5, 0, 0, 64'd5);          expect_word("clr.next", 32'h00500293, 8'd4, 1'b0);

      // err_cnt saturation; address must not move
      for (int i = 0; i < 256; i++) send(I_ADDI, 1, 1, 0, 64'd4096);
      chk("sat.cnt", 64'(a.err_cnt), 64'd255);
      expect_word("sat.w", 32'h00000013, 8'd8, 1'b1);

      // addr_clr alone
      @(negedge clk);
      a.addr_clr = 1'b1;
      @(posedge clk);
      #1;
      a.addr_clr = 1'b0;
      chk("clronly.cnt", 64'(a.err_cnt), 64'd0);
      send(I_ADDI, 6, 0, 0, 64'd6);          expect_word("clronly.x", 32'h00600313, 8'd0, 1'b0);
      send(I_ADDI, 7, 0, 0, 64'd7);          expect_word("clronly.y", 32'h00700393, 8'd4, 1'b0);

      // async reset while the held word is stalled
      @(negedge clk);
      a.out_ready = 1'b0;
      #2;
      chk("stall.valid", 64'(a.out_valid), 64'd1);
      rst_n = 1'b0;
      #1;
      chk("arst.valid", 64'(a.out_valid), 64'd0);
      chk("arst.addr",  64'(a.out_addr),  64'd0);
      chk("arst.ready", 64'(a.in_ready),  64'd1);
      @(negedge clk);
      rst_n = 1'b1;
      a.out_ready = 1'b1;

      // random round trip through the immediate generator
      for (int i = 0; i < 24; i++) begin
         op_e         op;
         longint      simm;
         logic [63:0] imm, g;
         op   = op_e'(4 + $urandom_range(3));
         simm = longint'($urandom_range(4095)) - 2048;
         imm  = simm;
         send(op, int'($urandom_range(31)), int'($urandom_range(31)), int'($urandom_range(31)), imm);
         g = immgen(a.out_instr);
         if (op == I_BEQ) chk($sformatf("rt%0d.beq", i), g, {imm[62:0], 1'b0});
         else             chk($sformatf("rt%0d.imm", i), g, imm);
         chk($sformatf("rt%0d.addr", i), 64'(a.out_addr), 64'((i * 4) % 256));
      end

      $display("Result: errors=%0d of %0d checks", errors, checks);
      $finish;
   end

endmodule

// File: doc/instr_encoder.md
# instr_encoder

Pipelined RISC-V instruction encoder: the inverse of the core's immediate generator and decoder path. It accepts symbolic instruction fields over a valid/ready stream, packs them into 32-bit RV64 encodings, and emits each word with its instruction-memory byte address. It sits between the test/boot loader and the instruction-memory write port. Encodings round-trip exactly through the core's immediate generator.

## Interface
- ADDR_W, 8: byte-address width of the instruction-memory write port.
- BASE_ADDR, 0: first write address after reset or `addr_clr`. Must be a multiple of 4.
- clk  in  1  clock; all state updates on the rising edge.
- rst_n  in  1  reset; **asynchronous, active-low**.
- in_valid  in  1  input word valid.
- in_ready  out  1  encoder can accept; equals `!out_valid || out_ready`.
- in_op  in  3  0 ADD, 1 SUB, 2 AND, 3 OR, 4 ADDI, 5 LD, 6 SD, 7 BEQ.
- in_rd, in_rs1, in_rs2  in  5 each  register indices.
- in_imm  in  64  signed immediate. For BEQ it is the halfword offset, i.e. byte offset >> 1.
- addr_clr  in  1  synchronous restart: sets the address counter to BASE_ADDR and clears `err_cnt`.
- out_valid  out  1  output word valid.
- out_ready  in  1  downstream accepts.
- out_instr  out  32  encoded instruction.
- out_addr  out  ADDR_W  byte address for `out_instr`.
- out_err  out  1  the immediate was out of range for this word.
- err_cnt  out  8  saturating count of error words accepted.

## Operation
- **Opcodes and function fields**
  - R-type: opcode 0110011; funct3 000 (ADD, SUB), 111 (AND), 110 (OR); funct7 0100000 for SUB, otherwise 0.
  - ADDI: opcode 0010011, funct3 000.
  - LD: opcode 0000011, funct3 011.
  - SD: opcode 0100011, funct3 011.
  - BEQ: opcode 1100011, funct3 000.
- **Immediate placement** (v = in_imm[11:0])
  - I-type: [31:20] = v.
  - S-type: [31:25] = v[11:5], [11:7] = v[4:0].
  - B-type: [31] = v[11], [7] = v[10], [30:25] = v[9:4], [11:8] = v[3:0].
- **Field use**
  - R-type ignores `in_imm`.
  - SD and BEQ ignore `in_rd`.
  - ADDI and LD ignore `in_rs2`.
  - Unused fields never leak into the encoding.
- **Range check** (non-R ops): in_imm must equal the sign-extension of in_imm[11:0], i.e. lie in -2048..2047. If it does not:
  - out_instr = 0x00000013 (NOP), out_err = 1;
  - the address counter does not advance;
  - err_cnt increments, saturating at 255.
- **Address counter**
  - Each accepted non-error word takes the current counter value as `out_addr`; the counter then adds 4, modulo 2^ADDR_W.
  - Error words carry the current counter value without advancing it.
- **addr_clr**
  - With no accept in the same cycle: counter ← BASE_ADDR, err_cnt ← 0.
  - With a simultaneous accept: the accepted word gets BASE_ADDR, the counter becomes BASE_ADDR+4 (BASE_ADDR if it was an error word), and err_cnt becomes 0 or 1 accordingly.
  - addr_clr does not affect a word already held in the output register.

## Timing
- Single output register; latency 1 cycle from accept (in_valid && in_ready) to out_valid.
- Throughput is 1 word/cycle while out_ready = 1.
- **Backpressure:** while out_valid && !out_ready, out_instr, out_addr and out_err stay stable and in_ready = 0.
- **Simultaneous pop and push:** when out_ready = 1 and a new word is accepted in the same cycle, the register reloads with no bubble.
- **Reset values:** out_valid 0, out_instr 0, out_addr BASE_ADDR, out_err 0, err_cnt 0, counter BASE_ADDR; in_ready = 1.
- **Reset mid-operation:** rst_n low drops the held word immediately and asynchronously; no partial output.

## Structure
- Shared package `riscv_enc_pkg` holds:
  - the op enum (3 bits);
  - opcode constants OP_R, OP_IMM, OP_LOAD, OP_STORE, OP_BRANCH;
  - funct3/funct7 constants;
  - NOP = 0x00000013.
- Sub-module `instr_pack` is purely combinational and covers field packing plus the range check.
- The top level holds the output register, handshake, address counter and err_cnt.

## Test plan
- **Encodings**, out_ready = 1, BASE_ADDR = 0:
  - ADDI rd=5, rs1=0, imm=-1 → 0xFFF00293 @ addr 0.
  - LD rd=6, rs1=2, imm=16 → 0x01013303 @ 4.
  - SD rs1=2, rs2=6, imm=8 → 0x00613423 @ 8.
  - SUB rd=1, rs1=2, rs2=3 → 0x403100B3 @ 12.
  - BEQ rs1=1, rs2=2, imm=-2 → 0xFE208EE3 @ 16.
- **Range error:** ADDI imm=2048 → out_instr 0x00000013, out_err 1, err_cnt 1. The next valid word takes the same out_addr.
- **Backpressure:** hold out_ready = 0 for 3 cycles with in_valid = 1 → in_ready 0 and outputs stable. Raise out_ready → 1 word/cycle with no loss or duplication.
- **Wrap and clear:**
  - ADDR_W = 4: five accepted words → addresses 0, 4, 8, 12, 0.
  - addr_clr in the same cycle as an accept → that word gets BASE_ADDR and the next word gets BASE_ADDR+4.
- **Async reset mid-stall:** rst_n low while out_valid = 1 → out_valid 0 immediately and out_addr = BASE_ADDR.
- **Round trip (random):** feed every out_instr to the core's immediate generator → its output equals the sign-extended in_imm for ADDI, LD, SD and BEQ.
